// File: rtl/percept_seq.sv
`default_nettype none
// ============================================================================
// Module      : percept_seq
// Description : Sequencer for the bit-serial perceptron datapath. Takes a job
//               request and a stream of parallel operand pairs (x then w),
//               serialises each operand MSB-first into the datapath, pulses
//               a multiply-accumulate per pair, then shifts the accumulator
//               back out and presents it as a parallel result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   clock
//   nRst         in   asynchronous active-low reset
//   start        in   job request, sampled only while idle
//   busy         out  job in progress (from cycle after accept through DONE)
//   op_valid     in   upstream operand available
//   op_ready     out  sequencer can accept an operand
//   op_data      in   operand (x first, then w, per MAC step)
//   shift_in     out  datapath: shift data_in into operand register
//   shift_out    out  datapath: shift accumulator out on data_out
//   mul_and_acc  out  datapath: acc += x*w
//   data_in      out  datapath: serial operand bit
//   data_out     in   datapath: serial accumulator bit, MSB first
//   result       out  last completed accumulator value
//   result_valid out  one-cycle pulse while a fresh result is presented
// ============================================================================
module percept_seq #(
    parameter int DATA_W   = 8,
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic              shift_in,
    output logic              shift_out,
    output logic              mul_and_acc,
    output logic              data_in,
    input  logic              data_out,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid
);

    localparam int c_MAXW = (DATA_W > ACC_W) ? DATA_W : ACC_W;
    localparam int c_BCW  = (c_MAXW > 1) ? $clog2(c_MAXW) : 1;
    localparam int c_MCW  = $clog2(N_INPUTS) + 1;

    localparam logic [c_BCW-1:0] c_DATA_LAST = c_BCW'(DATA_W - 1);
    localparam logic [c_BCW-1:0] c_ACC_LAST  = c_BCW'(ACC_W - 1);
    localparam logic [c_MCW-1:0] c_MAC_LAST  = c_MCW'(N_INPUTS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_SHIFT  = 3'd2;
    localparam logic [2:0] c_MAC    = 3'd3;
    localparam logic [2:0] c_UNLOAD = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [c_BCW-1:0]  r_bit_cnt;
    logic [c_MCW-1:0]  r_mac_cnt;
    logic              r_sel;      // 0: current operand is x, 1: w
    logic [DATA_W-1:0] r_sr;
    logic [ACC_W-1:0]  r_cap;
    logic [ACC_W-1:0]  r_result;

    // Newest captured bit enters at the LSB, so the first bit read ends as MSB.
    logic [ACC_W-1:0]  w_cap_next;
    assign w_cap_next = {r_cap[ACC_W-2:0], data_out};

    // All outputs decode directly from the state register, which keeps them
    // glitch-free relative to the state and makes the controls mutually
    // exclusive by construction.
    assign busy         = (r_state != c_IDLE);
    assign op_ready     = (r_state == c_LOAD);
    assign shift_in     = (r_state == c_SHIFT);
    assign data_in      = (r_state == c_SHIFT) & r_sr[DATA_W-1];
    assign mul_and_acc  = (r_state == c_MAC);
    assign shift_out    = (r_state == c_UNLOAD);
    assign result_valid = (r_state == c_DONE);
    assign result       = r_result;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= '0;
            r_mac_cnt <= '0;
            r_sel     <= 1'b0;
            r_sr      <= '0;
            r_cap     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_mac_cnt <= '0;
                        r_sel     <= 1'b0;
                        r_state   <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (op_valid) begin
                        r_sr      <= op_data;
                        r_bit_cnt <= '0;
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_sr      <= {r_sr[DATA_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                    if (r_bit_cnt == c_DATA_LAST) begin
                        r_sel   <= ~r_sel;
                        r_state <= r_sel ? c_MAC : c_LOAD;
                    end
                end
                c_MAC: begin
                    r_mac_cnt <= r_mac_cnt + c_MCW'(1);
                    if (r_mac_cnt == c_MAC_LAST) begin
                        r_bit_cnt <= '0;
                        r_state   <= c_UNLOAD;
                    end else begin
                        r_state   <= c_LOAD;
                    end
                end
                c_UNLOAD: begin
                    r_cap     <= w_cap_next;
                    r_bit_cnt <= r_bit_cnt + c_BCW'(1);
                    if (r_bit_cnt == c_ACC_LAST) begin
                        // Load the result as the last bit arrives so it is
                        // already stable during the DONE pulse.
                        r_result <= w_cap_next;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_percept_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_percept_seq
// Description : Directed self-checking bench for percept_seq with a small
//               behavioural model of the bit-serial perceptron datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_percept_seq;

    localparam int DATA_W   = 8;
    localparam int N_INPUTS = 4;
    localparam int ACC_W    = 16;

    logic              clk = 1'b0;
    logic              nRst;
    logic              start;
    logic              busy;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic              shift_in;
    logic              shift_out;
    logic              mul_and_acc;
    logic              data_in;
    logic              data_out;
    logic [ACC_W-1:0]  result;
    logic              result_valid;

    percept_seq #(
        .DATA_W   (DATA_W),
        .N_INPUTS (N_INPUTS),
        .ACC_W    (ACC_W)
    ) u_dut (
        .clk          (clk),
        .nRst         (nRst),
        .start        (start),
        .busy         (busy),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_data      (op_data),
        .shift_in     (shift_in),
        .shift_out    (shift_out),
        .mul_and_acc  (mul_and_acc),
        .data_in      (data_in),
        .data_out     (data_out),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Operand stream: x0,w0,x1,w1,... ; 3*2 + 1*5 + 0*127 + 4*4 = 27
    logic [7:0] ops [8] = '{8'h03, 8'h02, 8'h01, 8'h05, 8'h00, 8'h7F, 8'h04, 8'h04};
    localparam logic [63:0] c_DIN_EXP = 64'h0302_0105_007F_0404;
    localparam logic [15:0] c_RES_EXP = 16'h001B;

    logic        m_clr;
    logic        valid_en;
    logic        stall_en;
    logic [3:0]  idx;
    int          stall_cnt;
    logic [15:0] opreg;
    logic [15:0] acc;
    logic [63:0] din_cap;
    int          mac_pulses, rv_pulses, excl_bad, ctl_bad, so_run, so_runs, so_bad;

    assign op_data  = ops[idx[2:0]];
    assign op_valid = valid_en && !(stall_en && idx == 4'd3 && stall_cnt < 5);
    assign data_out = acc[15];

    // Datapath model plus per-job monitors
    always @(posedge clk) begin
        if (m_clr) begin
            idx <= '0; stall_cnt <= 0; opreg <= '0; acc <= '0; din_cap <= '0;
            mac_pulses <= 0; rv_pulses <= 0; excl_bad <= 0; ctl_bad <= 0;
            so_run <= 0; so_runs <= 0; so_bad <= 0;
        end else begin
            if (op_valid && op_ready) idx <= idx + 4'd1;
            if (stall_en && idx == 4'd3 && op_ready && !op_valid) stall_cnt <= stall_cnt + 1;
            if (shift_in) begin
                opreg   <= {opreg[14:0], data_in};
                din_cap <= {din_cap[62:0], data_in};
            end
            if (mul_and_acc) begin
                acc        <= acc + opreg[15:8] * opreg[7:0];
                mac_pulses <= mac_pulses + 1;
            end
            if (shift_out) acc <= {acc[14:0], 1'b0};
            if (int'(shift_in) + int'(shift_out) + int'(mul_and_acc) > 1) excl_bad <= excl_bad + 1;
            if (op_ready && (shift_in || shift_out || mul_and_acc)) ctl_bad <= ctl_bad + 1;
            if (result_valid) rv_pulses <= rv_pulses + 1;
            if (shift_out) begin
                so_run <= so_run + 1;
            end else if (so_run != 0) begin
                so_runs <= so_runs + 1;
                if (so_run != ACC_W) so_bad <= so_bad + 1;
                so_run <= 0;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {41'd0, busy, op_ready, shift_in, shift_out, mul_and_acc,
                data_in, result_valid, result};
    endfunction

    task automatic run_job(input string tag, input int exp_done, input bit inject,
                           input int abort_at, input bit stall);
        int cyc;
        bit seen;
        bit aborted;
        @(negedge clk);
        m_clr    = 1'b1;
        stall_en = stall;
        @(negedge clk);
        m_clr = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; seen = 1'b0; aborted = 1'b0;
        while (!seen && !aborted && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = inject && (cyc == 4 || cyc == 79);
            if (cyc == 1) check_val({tag, " busy_c1"}, 64'(busy), 64'd1);
            if (cyc == abort_at) begin
                nRst = 1'b0;
                #1;
                check_val({tag, " abort_outs"}, out_vec(), 64'd0);
                aborted = 1'b1;
            end else if (result_valid) begin
                seen = 1'b1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_val({tag, " abort_hold"}, out_vec(), 64'd0);
            nRst = 1'b1;
            return;
        end
        check_val({tag, " done_seen"}, 64'(seen), 64'd1);
        check_val({tag, " done_cycle"}, 64'(cyc), 64'(exp_done));
        check_val({tag, " result"}, 64'(result), 64'(c_RES_EXP));
        @(negedge clk);
        check_val({tag, " busy_after"}, 64'(busy), 64'd0);
        check_val({tag, " rv_after"}, 64'(result_valid), 64'd0);
        check_val({tag, " result_hold"}, 64'(result), 64'(c_RES_EXP));
        check_val({tag, " din_stream"}, din_cap, c_DIN_EXP);
        check_val({tag, " mac_pulses"}, 64'(mac_pulses), 64'(N_INPUTS));
        check_val({tag, " rv_pulses"}, 64'(rv_pulses), 64'd1);
        check_val({tag, " exclusive"}, 64'(excl_bad), 64'd0);
        check_val({tag, " load_ctl_low"}, 64'(ctl_bad), 64'd0);
        check_val({tag, " so_runs"}, 64'(so_runs), 64'd1);
        check_val({tag, " so_len"}, 64'(so_bad), 64'd0);
        if (stall) check_val({tag, " stall_cnt"}, 64'(stall_cnt), 64'd5);
        if (inject) begin
            repeat (30) @(negedge clk);
            check_val({tag, " no_restart"}, 64'(busy), 64'd0);
            check_val({tag, " rv_once"}, 64'(rv_pulses), 64'd1);
        end
    endtask

    initial begin
        nRst     = 1'b0;
        start    = 1'b1;
        valid_en = 1'b1;
        stall_en = 1'b0;
        m_clr    = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_outs_a", out_vec(), 64'd0);
        repeat (2) @(negedge clk);
        check_val("reset_outs_b", out_vec(), 64'd0);
        start = 1'b0;
        @(negedge clk);
        nRst  = 1'b1;
        m_clr = 1'b0;

        run_job("job_basic", 93, 1'b0, 0, 1'b0);
        run_job("job_stall", 98, 1'b0, 0, 1'b1);
        run_job("job_inject", 93, 1'b1, 0, 1'b0);
        run_job("job_abort", 0, 1'b0, 85, 1'b0);
        check_val("abort_result", 64'(result), 64'd0);
        run_job("job_after_abort", 93, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
